// File: rtl/md_sched_pkg.sv
// Shared op codes, FSM state encoding and helpers for the E-stage multiply/divide sequencer.
package md_sched_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    localparam int CNT_W = 8;

    // Only these four ops launch a busy window; anything else on a start pulse is a no-op.
    function automatic logic is_start_op(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_div_op(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_sched_if.sv
// E/D-stage side of the multiply/divide sequencer: op launch, mthi/mtlo, stall and HI/LO.
// Handshake: an op is accepted on any edge where E_start is high and busy is low; no ready
// signal exists, the pipeline must honour stall_req instead of retrying.
interface md_sched_if;
    import md_sched_pkg::*;

    logic        E_start;
    md_op_e      E_md_op;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        E_mt_we;
    logic        D_is_md;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;
    md_state_e   dbg_state;

    modport master (
        output E_start, E_md_op, E_A, E_B, E_mt_we, D_is_md,
        input  busy, stall_req, hi, lo, dbg_state
    );

    modport slave (
        input  E_start, E_md_op, E_A, E_B, E_mt_we, D_is_md,
        output busy, stall_req, hi, lo, dbg_state
    );

endinterface

// File: rtl/md_compute.sv
// Combinational mult/div datapath: returns {hi,lo} for the op plus a divide-by-zero flag.
module md_compute
    import md_sched_pkg::*;
(
    input  md_op_e      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        div0
);

    logic signed [63:0] s_prod;
    logic        [63:0] u_prod;
    logic        [31:0] b_safe;
    logic        [31:0] abs_a;
    logic        [31:0] abs_b;
    logic        [31:0] mag_q;
    logic        [31:0] mag_r;
    logic        [31:0] s_quot;
    logic        [31:0] s_rem;

    assign s_prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign u_prod = {32'd0, a} * {32'd0, b};

    // Divider never sees zero; the div0 flag tells the sequencer to drop the result.
    assign div0   = is_div_op(op) && (b == 32'd0);
    assign b_safe = (b == 32'd0) ? 32'd1 : b;

    // Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000 cleanly.
    assign abs_a  = a[31] ? (32'd0 - a) : a;
    assign abs_b  = b_safe[31] ? (32'd0 - b_safe) : b_safe;
    assign mag_q  = abs_a / abs_b;
    assign mag_r  = abs_a % abs_b;
    assign s_quot = (a[31] ^ b_safe[31]) ? (32'd0 - mag_q) : mag_q;
    assign s_rem  = a[31] ? (32'd0 - mag_r) : mag_r;

    always_comb begin
        result = 64'd0;
        case (op)
            MD_MULT:  result = s_prod;
            MD_MULTU: result = u_prod;
            MD_DIV:   result = {s_rem, s_quot};
            MD_DIVU:  result = {b_safe == 32'd0 ? 32'd0 : a % b_safe, a / b_safe};
            default:  result = 64'd0;
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// Mult/div sequencer: fixed-latency busy window, pending result registers, HI/LO commit
// and the D-stage stall request.
module md_sched
    import md_sched_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic     clk,
    input  logic     reset,
    md_sched_if.slave bus
);

    md_state_e         state_q;
    md_state_e         state_d;
    logic [CNT_W-1:0]  count_q;
    logic [31:0]       pend_hi;
    logic [31:0]       pend_lo;
    logic              pend_div0;
    logic [31:0]       hi_q;
    logic [31:0]       lo_q;
    logic [63:0]       calc_result;
    logic              calc_div0;
    logic              start_ok;
    logic              commit;

    md_compute u_compute (
        .op     (bus.E_md_op),
        .a      (bus.E_A),
        .b      (bus.E_B),
        .result (calc_result),
        .div0   (calc_div0)
    );

    assign start_ok = bus.E_start && is_start_op(bus.E_md_op);

    always_ff @(posedge clk) begin
        if (reset) state_q <= MD_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_IDLE: if (start_ok) state_d = MD_BUSY;
            MD_BUSY: if (count_q == CNT_W'(1)) state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    always_comb begin
        commit        = (state_q == MD_BUSY) && (count_q == CNT_W'(1));
        bus.busy      = (state_q == MD_BUSY);
        bus.stall_req = bus.D_is_md && (bus.E_start || (state_q == MD_BUSY));
        bus.hi        = hi_q;
        bus.lo        = lo_q;
        bus.dbg_state = state_q;
    end

    // Operands are captured at launch so the forwarded E_A/E_B may change while busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            pend_hi   <= '0;
            pend_lo   <= '0;
            pend_div0 <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else if (state_q == MD_IDLE) begin
            if (start_ok) begin
                pend_hi   <= calc_result[63:32];
                pend_lo   <= calc_result[31:0];
                pend_div0 <= calc_div0;
                count_q   <= is_div_op(bus.E_md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            end else if (bus.E_mt_we && !bus.E_start) begin
                if (bus.E_md_op == MD_MTHI) hi_q <= bus.E_A;
                if (bus.E_md_op == MD_MTLO) lo_q <= bus.E_A;
            end
        end else begin
            count_q <= count_q - CNT_W'(1);
            if (commit && !pend_div0) begin
                hi_q <= pend_hi;
                lo_q <= pend_lo;
            end
        end
    end

    a_no_start_busy: assert property (@(posedge clk) disable iff (reset)
        !((state_q == MD_BUSY) && bus.E_start));

    a_no_mt_busy: assert property (@(posedge clk) disable iff (reset)
        !((state_q == MD_BUSY) && bus.E_mt_we));

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: op latency, HI/LO results, div-by-zero hold, stall and reset abort.
module tb_md_sched;
    import md_sched_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    md_sched_if bus();

    md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Caller is at a negedge; returns at the negedge after the commit edge.
    task automatic run_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                          input int exp_cycles, input string tag);
        int cycles;
        bus.E_start = 1'b1;
        bus.E_md_op = op;
        bus.E_A     = a;
        bus.E_B     = b;
        @(negedge clk);
        bus.E_start = 1'b0;
        bus.E_A     = 32'h5a5a_5a5a;
        bus.E_B     = 32'h0000_0000;
        cycles = 0;
        while (bus.busy && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
        check_eq({tag, "_busy_cycles"}, 32'(cycles), 32'(exp_cycles));
    endtask

    task automatic do_mt(input md_op_e op, input logic [31:0] a);
        bus.E_mt_we = 1'b1;
        bus.E_md_op = op;
        bus.E_A     = a;
        @(negedge clk);
        bus.E_mt_we = 1'b0;
    endtask

    initial begin
        int stall_cycles;
        n_checks = 0;
        n_errors = 0;
        reset       = 1'b1;
        bus.E_start = 1'b0;
        bus.E_md_op = MD_NONE;
        bus.E_A     = '0;
        bus.E_B     = '0;
        bus.E_mt_we = 1'b0;
        bus.D_is_md = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check_eq("rst_busy",  32'(bus.busy), 32'd0);
        check_eq("rst_hi",    bus.hi, 32'd0);
        check_eq("rst_lo",    bus.lo, 32'd0);
        check_eq("rst_stall", 32'(bus.stall_req), 32'd0);
        check_eq("rst_state", 32'(bus.dbg_state), 32'(MD_IDLE));

        // signed multiply: -2 * 3
        run_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, 5, "mult");
        check_eq("mult_hi", bus.hi, 32'hFFFF_FFFF);
        check_eq("mult_lo", bus.lo, 32'hFFFF_FFFA);

        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, "multu");
        check_eq("multu_hi", bus.hi, 32'hFFFF_FFFE);
        check_eq("multu_lo", bus.lo, 32'h0000_0001);

        run_op(MD_DIVU, 32'd7, 32'd2, 10, "divu");
        check_eq("divu_hi", bus.hi, 32'd1);
        check_eq("divu_lo", bus.lo, 32'd3);

        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, "div_neg");
        check_eq("div_neg_hi", bus.hi, 32'hFFFF_FFFF);
        check_eq("div_neg_lo", bus.lo, 32'hFFFF_FFFD);

        run_op(MD_DIV, 32'd7, 32'hFFFF_FFFE, 10, "div_negb");
        check_eq("div_negb_hi", bus.hi, 32'd1);
        check_eq("div_negb_lo", bus.lo, 32'hFFFF_FFFD);

        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, "div_ovf");
        check_eq("div_ovf_hi", bus.hi, 32'd0);
        check_eq("div_ovf_lo", bus.lo, 32'h8000_0000);

        // divide by zero keeps the values written by mthi/mtlo
        do_mt(MD_MTHI, 32'h11);
        do_mt(MD_MTLO, 32'h22);
        check_eq("mt_hi", bus.hi, 32'h11);
        check_eq("mt_lo", bus.lo, 32'h22);
        run_op(MD_DIV, 32'd9, 32'd0, 10, "div0");
        check_eq("div0_hi", bus.hi, 32'h11);
        check_eq("div0_lo", bus.lo, 32'h22);

        // start pulse with a non-arithmetic op does nothing
        bus.E_start = 1'b1;
        bus.E_md_op = MD_MTHI;
        bus.E_A     = 32'h99;
        @(negedge clk);
        bus.E_start = 1'b0;
        check_eq("badop_busy", 32'(bus.busy), 32'd0);
        check_eq("badop_hi",   bus.hi, 32'h11);

        // stall: start cycle plus the five busy cycles
        bus.D_is_md = 1'b1;
        bus.E_start = 1'b1;
        bus.E_md_op = MD_MULT;
        bus.E_A     = 32'd4;
        bus.E_B     = 32'd5;
        #1;
        stall_cycles = 0;
        while (bus.stall_req && stall_cycles < 100) begin
            stall_cycles++;
            @(negedge clk);
            bus.E_start = 1'b0;
            #1;
        end
        check_eq("stall_cycles", 32'(stall_cycles), 32'd6);
        check_eq("stall_lo",     bus.lo, 32'd20);
        check_eq("stall_busy",   32'(bus.busy), 32'd0);
        @(negedge clk);
        bus.D_is_md = 1'b0;

        // reset aborts a divide in flight
        bus.E_start = 1'b1;
        bus.E_md_op = MD_DIVU;
        bus.E_A     = 32'd100;
        bus.E_B     = 32'd7;
        @(negedge clk);
        bus.E_start = 1'b0;
        @(negedge clk);
        check_eq("abort_busy_pre", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("abort_busy", 32'(bus.busy), 32'd0);
        check_eq("abort_hi",   bus.hi, 32'd0);
        check_eq("abort_lo",   bus.lo, 32'd0);
        repeat (12) @(negedge clk);
        check_eq("abort_hi_late", bus.hi, 32'd0);
        run_op(MD_MULT, 32'hFFFF_FFFD, 32'd5, 5, "post_rst");
        check_eq("post_rst_hi", bus.hi, 32'hFFFF_FFFF);
        check_eq("post_rst_lo", bus.lo, 32'hFFFF_FFF1);

        // mtlo in idle, then two mults back-to-back
        do_mt(MD_MTLO, 32'hDEAD);
        check_eq("mtlo_lo", bus.lo, 32'hDEAD);
        check_eq("mtlo_hi", bus.hi, 32'hFFFF_FFFF);
        run_op(MD_MULTU, 32'h0001_0000, 32'h0003_0000, 5, "b2b_a");
        check_eq("b2b_a_hi", bus.hi, 32'd3);
        check_eq("b2b_a_lo", bus.lo, 32'd0);
        run_op(MD_MULT, 32'd6, 32'd7, 5, "b2b_b");
        check_eq("b2b_b_hi", bus.hi, 32'd0);
        check_eq("b2b_b_lo", bus.lo, 32'd42);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
